// File: rtl/knn_dist_engine.sv
// Streaming squared-Euclidean distance engine on cache port s2: loads the query
// vector once, then streams every training vector and emits (distance, index) results.
module knn_dist_engine #(
  parameter int W  = 4,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] query_base,
  input  logic [AW-1:0] train_base,
  input  logic [9:0]    num_vec,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] address2,
  output logic          chipselect2,
  output logic          clken2,
  output logic          write2,
  output logic [3:0]    byteenable2,
  output logic [31:0]   writedata2,
  input  logic [31:0]   readdata2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_dist,
  output logic [9:0]    out_index
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_Q,
    S_RUN,
    S_DRAIN,
    S_FIN
  } state_t;

  localparam logic [2:0] LAST_WORD = 3'(W - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] train_base_q, train_base_d;
  logic [9:0]    num_q, num_d;
  logic          cs_q, cs_d;
  logic [2:0]    iw_q, iw_d;
  logic [9:0]    iv_q, iv_d;
  logic          vld_q, vld_d;
  logic          kind_q, kind_d;
  logic [2:0]    widx_q, widx_d;
  logic [9:0]    vidx_q, vidx_d;
  logic [21:0]   acc_q, acc_d;
  logic [21:0]   dist_q, dist_d;
  logic [9:0]    idx_q, idx_d;
  logic          ov_q, ov_d;
  logic [31:0]   qreg_q [8];

  logic          stall;
  logic          qwe;
  logic [31:0]   qsel;
  logic [15:0]   sq [4];
  logic [17:0]   psum;

  // A held result freezes the whole read pipeline, including the cache address register.
  assign stall = ov_q & ~out_ready;
  assign qsel  = qreg_q[widx_q];

  // |t - q| squared equals the square of the 9-bit signed difference and stays within 16 bits.
  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    logic [7:0] t_b;
    logic [7:0] q_b;
    logic [7:0] ad;
    assign t_b     = readdata2[8*gi +: 8];
    assign q_b     = qsel[8*gi +: 8];
    assign ad      = (t_b >= q_b) ? (t_b - q_b) : (q_b - t_b);
    assign sq[gi]  = {8'd0, ad} * {8'd0, ad};
  end

  assign psum = 18'(sq[0]) + 18'(sq[1]) + 18'(sq[2]) + 18'(sq[3]);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    train_base_d = train_base_q;
    num_d        = num_q;
    cs_d         = cs_q;
    iw_d         = iw_q;
    iv_d         = iv_q;
    vld_d        = vld_q;
    kind_d       = kind_q;
    widx_d       = widx_q;
    vidx_d       = vidx_q;
    acc_d        = acc_q;
    dist_d       = dist_q;
    idx_d        = idx_q;
    ov_d         = ov_q;
    qwe          = 1'b0;

    if (!stall) begin
      if (ov_q && out_ready) ov_d = 1'b0;

      if (vld_q && kind_q) qwe = 1'b1;

      if (vld_q && !kind_q) begin
        if (widx_q == LAST_WORD) begin
          dist_d = acc_q + {4'd0, psum};
          idx_d  = vidx_q;
          ov_d   = 1'b1;
          acc_d  = '0;
        end else begin
          acc_d  = acc_q + {4'd0, psum};
        end
      end

      // Tag travelling alongside the address just issued, consumed next cycle.
      vld_d  = cs_q;
      kind_d = (state_q == S_LOAD_Q);
      widx_d = iw_q;
      vidx_d = iv_q;

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            train_base_d = train_base;
            num_d        = num_vec;
            addr_d       = query_base;
            iw_d         = '0;
            iv_d         = '0;
            if (num_vec == 10'd0) begin
              state_d = S_FIN;
            end else begin
              state_d = S_LOAD_Q;
              cs_d    = 1'b1;
            end
          end
        end
        S_LOAD_Q: begin
          if (iw_q == LAST_WORD) begin
            addr_d  = train_base_q;
            iw_d    = '0;
            iv_d    = '0;
            state_d = S_RUN;
          end else begin
            addr_d  = addr_q + AW'(1);
            iw_d    = iw_q + 3'd1;
          end
        end
        S_RUN: begin
          addr_d = addr_q + AW'(1);
          if (iw_q == LAST_WORD) begin
            iw_d = '0;
            iv_d = iv_q + 10'd1;
            if (iv_q == num_q - 10'd1) begin
              cs_d    = 1'b0;
              state_d = S_DRAIN;
            end
          end else begin
            iw_d = iw_q + 3'd1;
          end
        end
        S_DRAIN: begin
          if (!vld_q && !ov_q) state_d = S_FIN;
        end
        S_FIN: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      train_base_q <= '0;
      num_q        <= '0;
      cs_q         <= 1'b0;
      iw_q         <= '0;
      iv_q         <= '0;
      vld_q        <= 1'b0;
      kind_q       <= 1'b0;
      widx_q       <= '0;
      vidx_q       <= '0;
      acc_q        <= '0;
      dist_q       <= '0;
      idx_q        <= '0;
      ov_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      train_base_q <= train_base_d;
      num_q        <= num_d;
      cs_q         <= cs_d;
      iw_q         <= iw_d;
      iv_q         <= iv_d;
      vld_q        <= vld_d;
      kind_q       <= kind_d;
      widx_q       <= widx_d;
      vidx_q       <= vidx_d;
      acc_q        <= acc_d;
      dist_q       <= dist_d;
      idx_q        <= idx_d;
      ov_q         <= ov_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) qreg_q[i] <= '0;
    end else if (qwe) begin
      qreg_q[widx_q] <= readdata2;
    end
  end

  assign busy        = (state_q == S_LOAD_Q) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done        = (state_q == S_FIN);
  assign address2    = addr_q;
  assign chipselect2 = cs_q;
  assign clken2      = ~stall;
  assign write2      = 1'b0;
  assign byteenable2 = 4'hF;
  assign writedata2  = 32'd0;
  assign out_valid   = ov_q;
  assign out_dist    = {10'd0, dist_q};
  assign out_index   = idx_q;

endmodule

// File: doc/knn_dist_engine.md
# knn_dist_engine

Streaming squared-Euclidean distance engine that sits on port s2 of the 512x32 dual-port cache RAM in the KNN accelerator. Software writes the query vector and the training vectors into the cache through port s1. This block then reads the query once and streams every training vector through port s2. It emits one distance and vector index per training vector on a valid/ready output for the downstream k-smallest sorter.

## Interface
- `W`, default 4: 32-bit words per vector (4 unsigned 8-bit features per word, byte 0 = feature 0); legal range 1..8.
- `AW`, default 9: cache word-address width.
- `clk` in 1: single clock. Shared with the cache s2 clock.
- `reset_n` in 1: reset, synchronous and active-low.
- `start` in 1: one-cycle pulse to begin a job. Ignored while `busy`=1.
- `query_base` in AW: word address of the query vector. Sampled on `start`.
- `train_base` in AW: word address of training vector 0. Sampled on `start`.
- `num_vec` in 10: number of training vectors, 0..1023. Sampled on `start`.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle pulse at job completion.
- `address2` out AW: cache s2 address.
- `chipselect2` out 1: cache s2 select.
- `clken2` out 1: cache s2 clock enable. Deasserted to freeze the read pipeline.
- `write2` out 1: constant 0.
- `byteenable2` out 4: constant 4'hF.
- `writedata2` out 32: constant 0.
- `readdata2` in 32: cache s2 read data. Valid one cycle after its address was issued with `clken2`=1.
- `out_valid` out 1: result available.
- `out_ready` in 1: downstream accepts a result when `out_valid` & `out_ready`.
- `out_dist` out 32: squared distance, zero-extended.
- `out_index` out 10: training vector index, 0-based.

## Operation
- Reset (`reset_n`=0 at a clock edge): FSM→IDLE. The following outputs go to 0: `busy`, `done`, `out_valid`, `out_dist`, `out_index`, `chipselect2`, `address2`. `clken2` resets to 1. The query register file is cleared. Reset mid-job aborts the job immediately, with no `done` and no partial result.
- IDLE: `chipselect2`=0. On `start`, latch the three job inputs and go to LOAD_Q with `busy`=1. If `num_vec`=0, go instead to FIN: no cache reads are made, and `done` pulses on the next cycle.
- LOAD_Q: issue addresses `query_base`+0..W-1, one per cycle. Capture each returned word into query register j. After W issues, go to RUN.
- RUN: issue `train_base`+0..`num_vec`*W-1 sequentially, one per cycle. For each returned word, compute d_i = train_byte_i − query_byte_i for the 4 bytes, as 9-bit signed values. Sum d_i² (16 bits unsigned each) and add the sum into the 22-bit accumulator. On the W-th word of a vector, load `out_dist` with accumulator + partial, load `out_index` with the vector count, set `out_valid`, and clear the accumulator. After the last address is issued, go to DRAIN.
- DRAIN: wait until the last result is accepted, then go to FIN.
- FIN: one cycle with `done`=1 and `busy`=0, then go to IDLE.
- Address arithmetic is modulo 2^AW: 511+1 wraps to 0.
- Maximum distance is 32 features × 65025 = 2,080,800, which fits in 22 bits. There is no overflow.
- Stall: whenever `out_valid`=1 and `out_ready`=0, drive `clken2`=0 and hold all of the following: the address counter, the in-flight data-valid flag, the accumulator and the output register. The frozen cache address register keeps `readdata2` stable, so no word is lost or consumed twice.
- If a result is accepted in the same cycle a new one is loaded, the new result replaces it with no bubble.

## Timing
- Cache read latency is 1 cycle: address at cycle t gives data at cycle t+1.
- Take `start` as sampled at edge 0:
  - Query addresses are issued in cycles 1..W.
  - Training addresses start in cycle W+1.
  - The first `out_valid` is seen in cycle 2W+2.
- With `out_ready` held 1, throughput is one result every W cycles.
- `done` follows the final handshake cycle by 2 cycles: the handshake cycle leads to DRAIN, then FIN.
- `start` asserted while `busy`=1 has no effect.

## Test plan
- Basic distance: W=4, query words all 0x10101010, one training vector of words 0x12121212, `num_vec`=1, `out_ready`=1 → one result with `out_dist`=64 and `out_index`=0, first `out_valid` in cycle 10, then a `done` pulse.
- Extremes: query 0x00000000 ×4, training 0xFFFFFFFF ×4 → `out_dist`=1,040,400 (0xFE010). Swapping query and training gives the same value.
- Backpressure: `num_vec`=3 with distinct distances 0, 4 and 16, and `out_ready` low for 5 cycles after each `out_valid`. Required response: `clken2`=0 throughout each stall, results delivered in order (0,0), (1,4), (2,16), and exactly 3 handshakes.
- Wrap-around: `train_base`=510, W=4 → addresses issued are 510, 511, 0, 1, and the distance is correct for data placed there.
- Empty job: `num_vec`=0 → `chipselect2` never asserted, `out_valid` never set, `done` one cycle after `start`. A `start` during `busy` is ignored.
- Reset mid-RUN: `reset_n`=0 for one edge after 2 of 5 results → all outputs return to their reset values and no `done` is produced. A new `start` then produces the full 5-result sequence correctly.
